weight_shift_bank: RTL
======================

// Module: weight_shift_bank
// PURPOSE
//  Parametrised multi-column weight staging buffer for the systolic array.
//  - Accepts one row of COLS weights per valid/ready beat until DEPTH rows are held.
//  - On a start pulse, drains every column into the array top edge.
//  - Column c is delayed c cycles, giving the diagonal skew the PE grid needs.
//  - Sits between the weight fetch path and the PE column inputs.
// PARAMETERS
//  DATA_W  8  bits per weight
//  DEPTH   4  rows per column (array height), >=2
//  COLS    4  columns (array width), >=1
// PORTS
//  clk       in   1              clock
//  rst       in   1              synchronous reset, active-high
//  flush     in   1              synchronous clear to empty; same effect as rst on state
//  in_valid  in   1              load beat valid
//  in_ready  out  1              load beat ready
//  in_data   in   COLS*DATA_W    one row; column c at [c*DATA_W +: DATA_W]
//  start     in   1              drain request pulse
//  out_valid out  COLS           per-column output valid
//  out_data  out  COLS*DATA_W    per-column weight; zero when out_valid[c]=0
//  full      out  1              DEPTH rows held, drain not started
//  busy      out  1              state is DRAIN or skew pipe not empty
//  done      out  1              1-cycle pulse with last valid word of column COLS-1
// BEHAVIOUR
//  - Reset/flush: state IDLE, row count 0, storage 0, all outputs 0; in_ready=1 from the next cycle.
//  - FSM states:
//    - IDLE --beat--> LOAD
//    - LOAD --count==DEPTH--> FULL
//    - FULL --start--> DRAIN
//    - DRAIN --last skewed word--> IDLE
//  - Beat = in_valid & in_ready; in_ready=1 only in IDLE/LOAD (count<DEPTH).
//  - The DEPTH-th beat moves the FSM to FULL; in_ready drops in the same edge.
//  - Load shifts the row into slot 0; older rows move toward slot DEPTH-1.
//  - Drain emits slot 0 first, so the last-loaded row leaves first (LIFO), and shifts toward slot 0.
//  - Count is $clog2(DEPTH+1) bits, saturates at DEPTH.
//  - start is ignored outside FULL; in_valid is ignored outside IDLE/LOAD.
//  - Drain timing, with start sampled at edge T (registered outputs):
//    - column c has out_valid=1 for cycles T+1+c .. T+DEPTH+c;
//    - the column c word for drain cycle k is the column-0-aligned word delayed c cycles.
//  - done is asserted in cycle T+DEPTH+COLS-1; the FSM is IDLE the following cycle.
//  - Total drain length is DEPTH+COLS-1 cycles.
//  - flush or rst mid-load or mid-drain:
//    - storage, skew pipes and counters clear at that edge;
//    - out_valid=0 and no done pulse is issued.
//  - When flush and in_valid coincide, flush wins and the beat is dropped (in_ready is not honoured).
// CONFIGURATION
//  - WEIGHT_REUSE_EN defined: drain rotates each column, so slot 0 re-enters at slot DEPTH-1.
//    - After DEPTH shifts the contents are back in their original order.
//    - After done the FSM returns to FULL, so start may be issued again with no reload.
//    - Only flush or rst empties the bank.
//  - WEIGHT_REUSE_EN undefined: drain zero-fills slot DEPTH-1 and the FSM returns to IDLE after done.
// STRUCTURE
//  - Shared package sa_pkg:
//    - DATA_W/DEPTH/COLS defaults;
//    - typedef weight_t (logic [DATA_W-1:0]);
//    - enum wsb_state_e {IDLE, LOAD, FULL, DRAIN}.
//  - Sub-module wsb_skew_pipe #(DATA_W, STAGES):
//    - STAGES-deep register delay line for {valid, data}, cleared by rst|flush;
//    - instantiated per column with STAGES=c (c=0 is a wire).
//  - Top holds the FSM, row counter, drain counter and COLS x DEPTH storage.
// TESTING  (DATA_W=8, DEPTH=4, COLS=2)
//  - Load rows {c1,c0}={11,01},{12,02},{13,03},{14,04}, then start.
//    - col0 emits 04,03,02,01 on T+1..T+4.
//    - col1 emits 14,13,12,11 on T+2..T+5.
//    - done at T+5; IDLE at T+6.
//  - Hold in_valid=1 for 6 cycles: exactly 4 beats accepted, in_ready=0 after the 4th, full=1.
//  - start pulsed in IDLE and in LOAD (2 rows held): no out_valid; the count is unchanged.
//  - flush asserted at T+2 of a drain: out_valid=0 from T+3, no done, state IDLE, in_ready=1.
//  - WEIGHT_REUSE_EN: load as in the first test and start twice.
//    - Both drains produce an identical 04..01 / 14..11 sequence.
//    - full=1 after each done.
//  - rst mid-load (2 rows held), then a fresh load of 4 rows: only the new rows appear on drain.

Source files
------------

// File: rtl/sa_pkg.sv
// Shared systolic-array types: default geometry, weight word and staging-bank states.
package sa_pkg;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int COLS   = 4;

  typedef logic [DATA_W-1:0] weight_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FULL,
    DRAIN
  } wsb_state_e;

endpackage

// File: rtl/weight_shift_bank_if.sv
// Load/drain bus of the weight staging bank; the bank side uses the slave modport.
interface weight_shift_bank_if #(
  parameter int DATA_W = 8,
  parameter int COLS   = 4
);
  logic                   flush;
  logic                   in_valid;
  logic                   in_ready;
  logic [COLS*DATA_W-1:0] in_data;
  logic                   start;
  logic [COLS-1:0]        out_valid;
  logic [COLS*DATA_W-1:0] out_data;
  logic                   full;
  logic                   busy;
  logic                   done;

  modport master (
    output flush, in_valid, in_data, start,
    input  in_ready, out_valid, out_data, full, busy, done
  );

  modport slave (
    input  flush, in_valid, in_data, start,
    output in_ready, out_valid, out_data, full, busy, done
  );
endinterface

// File: rtl/wsb_skew_pipe.sv
// STAGES-deep {valid, data} delay line used to skew one array column; cleared by rst or flush.
module wsb_skew_pipe #(
  parameter int DATA_W = 8,
  parameter int STAGES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  logic [STAGES-1:0] vld;
  logic [DATA_W-1:0] dat [STAGES];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      vld <= '0;
      for (int i = 0; i < STAGES; i++) dat[i] <= '0;
    end else begin
      vld[0] <= in_valid;
      dat[0] <= in_data;
      for (int i = 1; i < STAGES; i++) begin
        vld[i] <= vld[i-1];
        dat[i] <= dat[i-1];
      end
    end
  end

  assign out_valid = vld[STAGES-1];
  assign out_data  = dat[STAGES-1];

endmodule

// File: rtl/weight_shift_bank.sv
// Weight staging bank: loads DEPTH rows, drains them LIFO with per-column diagonal skew.
// WEIGHT_REUSE_EN: drain rotates the columns and returns to FULL so start can repeat without reload.
module weight_shift_bank #(
  parameter int DATA_W = sa_pkg::DATA_W,
  parameter int DEPTH  = sa_pkg::DEPTH,
  parameter int COLS   = sa_pkg::COLS
) (
  input  logic               clk,
  input  logic               rst,
  weight_shift_bank_if.slave bus
);
  import sa_pkg::*;

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int CYC_W = $clog2(DEPTH + COLS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);
  localparam logic [CYC_W-1:0] CYC_EMIT = CYC_W'(DEPTH);
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(DEPTH + COLS - 1);

  wsb_state_e             state, state_nxt;
  logic [CNT_W-1:0]       count;
  logic [CYC_W-1:0]       cyc;
  logic [DATA_W-1:0]      mem [COLS][DEPTH];
  logic                   lane_vld;
  logic [DATA_W-1:0]      lane_dat [COLS];
  logic [COLS-1:0]        col_vld;
  logic [COLS*DATA_W-1:0] col_dat;
  logic                   beat, emit, last;

  assign bus.in_ready = ((state == IDLE) || (state == LOAD)) && (count < CNT_FULL);
  assign beat         = bus.in_valid && bus.in_ready;
  // First word leaves on the start edge; cyc 1..DEPTH-1 emit the rest.
  assign emit         = ((state == FULL) && bus.start) || ((state == DRAIN) && (cyc < CYC_EMIT));
  assign last         = (state == DRAIN) && (cyc == CYC_LAST);
  assign bus.full     = (state == FULL);
  assign bus.done     = last;
  assign bus.busy     = (state == DRAIN) || (|col_vld);
  assign bus.out_valid = col_vld;
  assign bus.out_data  = col_dat;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (beat) state_nxt = LOAD;
      LOAD:  if (beat && (count == CNT_LAST)) state_nxt = FULL;
      FULL:  if (bus.start) state_nxt = DRAIN;
      DRAIN: begin
        if (last) begin
`ifdef WEIGHT_REUSE_EN
          state_nxt = FULL;
`else
          state_nxt = IDLE;
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      state    <= IDLE;
      count    <= '0;
      cyc      <= '0;
      lane_vld <= 1'b0;
      for (int c = 0; c < COLS; c++) begin
        lane_dat[c] <= '0;
        for (int r = 0; r < DEPTH; r++) mem[c][r] <= '0;
      end
    end else begin
      state    <= state_nxt;
      lane_vld <= emit;

      if (beat) begin
        count <= count + 1'b1;
      end else if (last) begin
`ifdef WEIGHT_REUSE_EN
        count <= count;
`else
        count <= '0;
`endif
      end

      if ((state == FULL) && bus.start) cyc <= CYC_W'(1);
      else if (state == DRAIN)          cyc <= last ? '0 : cyc + 1'b1;

      for (int c = 0; c < COLS; c++) begin
        lane_dat[c] <= emit ? mem[c][0] : '0;
        if (beat) begin
          mem[c][0] <= bus.in_data[c*DATA_W +: DATA_W];
          for (int r = 1; r < DEPTH; r++) mem[c][r] <= mem[c][r-1];
        end else if (emit) begin
          for (int r = 0; r < DEPTH - 1; r++) mem[c][r] <= mem[c][r+1];
`ifdef WEIGHT_REUSE_EN
          mem[c][DEPTH-1] <= mem[c][0];
`else
          mem[c][DEPTH-1] <= '0;
`endif
        end
      end
    end
  end

  // Column c sees the column-0 stream delayed by c extra registers.
  for (genvar c = 0; c < COLS; c++) begin : g_col
    if (c == 0) begin : g_wire
      assign col_vld[0]          = lane_vld;
      assign col_dat[0 +: DATA_W] = lane_dat[0];
    end else begin : g_pipe
      wsb_skew_pipe #(.DATA_W(DATA_W), .STAGES(c)) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.flush),
        .in_valid  (lane_vld),
        .in_data   (lane_dat[c]),
        .out_valid (col_vld[c]),
        .out_data  (col_dat[c*DATA_W +: DATA_W])
      );
    end
  end

endmodule
